conv_window_reader: RTL
=======================

Name: conv_window_reader

Overview:
- Consumer-side reader for the 8-bit, 27x27 feature FWFT buffer.
- Drives the buffer's rd_en, consumes one feature per accepted cycle in raster order, and holds the two previous rows in internal line buffers.
- Emits every valid 3x3 convolution window (25x25 = 625 per frame) to the conv datapath over a valid/ready handshake.

Parameters:
- DATA_W, 8, feature width in bits
- IMG_W, 27, feature-map width (columns)
- IMG_H, 27, feature-map height (rows)
- K, 3, window edge; window = K*K features

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when IDLE
- in_valid  in  1  FWFT buffer has a feature at its head
- in_feature  in  DATA_W  FWFT head data, valid when in_valid=1
- rd_en  out  1  pop request to FWFT; a feature is consumed on a cycle where rd_en=1
- win_valid  out  1  window output valid
- win_ready  in  1  downstream accepts window
- win_data  out  K*K*DATA_W  element (r,c) at [(r*K+c)*DATA_W +: DATA_W]; r=0 oldest row, c=0 leftmost column
- busy  out  1  high in STREAM and DONE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0; col=0, row=0; state=IDLE. Line-buffer contents are don't-care; no output depends on them before refill.
- States:
  - IDLE: start=1 -> STREAM; row and col cleared.
  - STREAM: consume features. After the last feature (row=IH-1, col=IW-1) is consumed and any pending window is accepted -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
- start is ignored outside IDLE.
- rd_en = (state==STREAM) & in_valid & (!win_valid | win_ready) & !last_consumed. rd_en is combinational; no pop occurs when in_valid=0.
- Consume: on rd_en, in_feature is shifted into a K-row by K-column window shift register. The line buffers (K-1 rows of IMG_W entries, shift-register or circular) supply the two older rows for the current column.
- Counters: col and row are 5-bit counters. On consume, col increments; when col=IMG_W-1, col wraps to 0 and row increments.
- Window emit:
  - A consume at position (row>=K-1, col>=K-1) sets win_valid=1 on the next edge and loads win_data. Latency: 1 cycle from consume to win_valid.
  - Consumes at col<K-1 (row wrap) or row<K-1 produce no window. The column shift register still fills, so no stale data crosses a row boundary.
- Output handshake:
  - win_valid clears on win_valid & win_ready unless a new window is loaded the same cycle (back-to-back throughput: 1 window/cycle).
  - win_data and win_valid are held stable while win_valid=1 & win_ready=0.
- Backpressure: while a window is held un-accepted, rd_en=0, so the FIFO is not drained and no feature is lost.
- Counts per frame: exactly IMG_W*IMG_H consumes (729) and (IMG_W-K+1)*(IMG_H-K+1) windows (625).
- Reset mid-frame: immediate return to IDLE with outputs 0. A partially read FIFO is the producer's responsibility to flush.
- in_valid gaps: the pipeline freezes with no state change.

Optional Feature:
- Macro: WIN_COORD_EN.
- Defined: adds outputs win_row (5 bits) and win_col (5 bits) = top-left coordinate of the window in win_data, registered with and held alongside win_data; reset 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package conv_pkg:
  - DATA_W, IMG_W, IMG_H, K defaults
  - derived IDX_W = $clog2(IMG_W)
  - state enum typedef {IDLE, STREAM, DONE}
  - window typedef logic [K*K*DATA_W-1:0]
- Sub-module line_buffer: one row delay, IMG_W deep, DATA_W wide, shift on enable. Instantiated K-1 times, chained.

Test Plan:
1. Ramp in_feature 0..728 (mod 256 irrelevant, use 10-bit model), in_valid=1, win_ready=1, start -> 729 rd_en pulses, 625 windows.
   - First window arrives 1 cycle after consume #56: {0,1,2,27,28,29,54,55,56} (mod 256).
   - Last window: {672,673,674,699,700,701,726,727,728} mod 256.
   - frame_done pulses once, then IDLE.
2. win_ready=0 for 10 cycles while win_valid=1 -> rd_en=0 throughout, win_data unchanged; resume yields no missing or duplicated windows versus the model.
3. in_valid random 50% duty -> rd_en never high with in_valid=0; window sequence identical to test 1.
4. rst_n low asynchronously after 300 consumes -> all outputs 0 within the same cycle; new start reproduces test 1 results exactly.
5. start pulsed during STREAM and during DONE -> ignored; counts still 729/625, single frame_done.
6. WIN_COORD_EN defined -> first window (0,0), window following row wrap (1,0), last window (24,24).

Source files
------------

// File: rtl/conv_window_reader_pkg.sv
// Shared parameters and types for the 3x3 convolution window reader.
// Optional WIN_COORD_EN (in the top) adds window top-left coordinate outputs.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 27;
  localparam int IMG_H  = 27;
  localparam int K      = 3;
  localparam int IDX_W  = $clog2(IMG_W);
  localparam int WIN_W  = K * K * DATA_W;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  typedef logic [WIN_W-1:0] window_t;

endpackage

// File: rtl/conv_window_reader_line_buffer.sv
// One-row delay line: DEPTH entries of WIDTH bits, shifting on enable.
// Chained K-1 times by conv_window_reader to provide the older window rows.
module line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 27
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; every entry is rewritten before any window that reads it is emitted.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_reader.sv
// Reads a 27x27 feature map from an FWFT buffer and emits every valid 3x3 window.
// Define WIN_COORD_EN to add win_row/win_col (window top-left coordinate) outputs.
module conv_window_reader
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_feature,
  output logic              rd_en,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [WIN_W-1:0]  win_data,
`ifdef WIN_COORD_EN
  output logic [IDX_W-1:0]  win_row,
  output logic [IDX_W-1:0]  win_col,
`endif
  output logic              busy,
  output logic              frame_done
);

  state_t           state;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             last_consumed;
  logic             emit;
  window_t          win_sr;
  window_t          next_win;

  // tap[j] is the feature j rows above the current one at the same column.
  logic [DATA_W-1:0] tap [K];

  assign tap[0] = in_feature;

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    line_buffer #(.WIDTH(DATA_W), .DEPTH(IMG_W)) u_lb (
      .clk  (clk),
      .en   (rd_en),
      .din  (tap[i]),
      .dout (tap[i+1])
    );
  end

  assign rd_en = (state == STREAM) && in_valid && (!win_valid || win_ready) && !last_consumed;
  assign emit  = (row >= IDX_W'(K - 1)) && (col >= IDX_W'(K - 1));

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    next_win = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++)
        next_win[(r*K+c)*DATA_W +: DATA_W] = win_sr[(r*K+c+1)*DATA_W +: DATA_W];
      next_win[(r*K+K-1)*DATA_W +: DATA_W] = tap[K-1-r];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) win_sr <= next_win;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      last_consumed <= 1'b0;
      win_valid     <= 1'b0;
      win_data      <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
`ifdef WIN_COORD_EN
      win_row       <= '0;
      win_col       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (win_valid && win_ready) win_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= STREAM;
            busy          <= 1'b1;
            row           <= '0;
            col           <= '0;
            last_consumed <= 1'b0;
          end
        end
        STREAM: begin
          if (rd_en) begin
            if (col == IDX_W'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
              if (row == IDX_W'(IMG_H - 1)) last_consumed <= 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            // A new window overrides the accept-clear above for back-to-back output.
            if (emit) begin
              win_valid <= 1'b1;
              win_data  <= next_win;
`ifdef WIN_COORD_EN
              win_row   <= row - IDX_W'(K - 1);
              win_col   <= col - IDX_W'(K - 1);
`endif
            end
          end
          if (last_consumed && (!win_valid || win_ready)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
